// File: rtl/frame_writer.sv
// frame_writer: converts a raster-order 24-bit RGB pixel stream into 12-bit pixels and writes them
// into the back half of a double-buffered LED frame memory. At the end of each frame it flips
// buffer_select and holds off the next frame until the display side reports the flip on
// buffer_current, which is asynchronous and passes through a SYNC_STAGES-deep synchronizer.
//
// Optional feature macro: FRAME_WRITER_GAMMA_EN
//   defined   - each channel goes through a 256-entry synchronous gamma ROM (write latency N+2)
//   undefined - each channel is truncated to c[7:4] (write latency N+1)
//
// Ports:
//   clk, rst          write clock, synchronous active-high reset
//   in_valid/in_ready pixel handshake; in_sof marks pixel (0,0); in_data = {R,G,B} 8 bits each
//   wr, wr_addr       write strobe and address {~buffer_select, y[5:0], x[6:0]}
//   wr_data           {R[3:0], G[3:0], B[3:0]}
//   buffer_select     buffer the display should show after its next frame wrap
//   buffer_current    buffer the display is showing (asynchronous)
//   frame_done        one-cycle pulse when a swap completes
//   frame_err         one-cycle pulse on a framing error
module frame_writer #(
  parameter int unsigned WIDTH       = 96,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sof,
  input  logic [23:0] in_data,
  output logic        wr,
  output logic [13:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        buffer_select,
  input  logic        buffer_current,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic [2:0] {StSync, StIdle, StFill, StDrain, StSwap} state_e;

  localparam int unsigned CntW  = $clog2(SYNC_STAGES + 1);
  localparam logic [6:0]  XLast = 7'(WIDTH - 1);
  localparam logic [5:0]  YLast = 6'd63;

  state_e                 state_q, state_d;
  logic [6:0]             x_q, x_d;
  logic [5:0]             y_q, y_d;
  logic [CntW-1:0]        settle_q, settle_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   bsel_q, bsel_d;
  logic                   in_ready_q, in_ready_d;
  logic                   wr_q, wr_d;
  logic [13:0]            wr_addr_q, wr_addr_d;
  logic [11:0]            wr_data_q, wr_data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic       bc_sync;
  logic       accept;
  logic       wr_go;
  logic [6:0] px_x;
  logic [5:0] px_y;
  logic       pipe_busy;

`ifdef FRAME_WRITER_GAMMA_EN
  // Lowest input value that maps to output k+1 under round(15*(v/255)^2.2).
  localparam logic [7:0] GammaThr [15] = '{
    8'd55, 8'd90, 8'd113, 8'd132, 8'd148, 8'd162, 8'd175, 8'd187,
    8'd197, 8'd208, 8'd217, 8'd226, 8'd235, 8'd244, 8'd252
  };

  function automatic logic [3:0] gamma_lut(input logic [7:0] v);
    logic [3:0] g;
    g = '0;
    for (int k = 0; k < 15; k++) begin
      if (v >= GammaThr[k]) g = 4'(k + 1);
    end
    return g;
  endfunction

  logic        s1_valid_q, s1_valid_d;
  logic [13:0] s1_addr_q, s1_addr_d;
  logic [23:0] s1_rgb_q, s1_rgb_d;
`else
  // Low nibbles are dropped by truncation.
  logic unused_data;
  assign unused_data = ^{in_data[19:16], in_data[11:8], in_data[3:0]};
`endif

  assign bc_sync = sync_q[SYNC_STAGES-1];
  assign accept  = in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    settle_d   = settle_q;
    bsel_d     = bsel_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_go      = 1'b0;
    px_x       = x_q;
    px_y       = y_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], buffer_current};

    unique case (state_q)
      // Compare only once the synchronizer holds genuine samples, not its reset zeros.
      StSync: begin
        if (settle_q != CntW'(SYNC_STAGES)) begin
          settle_d = settle_q + CntW'(1);
        end else if (bc_sync == bsel_q) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (accept) begin
          if (in_sof) begin
            wr_go   = 1'b1;
            px_x    = '0;
            px_y    = '0;
            state_d = StFill;
            if (XLast == 7'd0) begin
              x_d = '0;
              y_d = 6'd1;
            end else begin
              x_d = 7'd1;
              y_d = '0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StFill: begin
        if (accept) begin
          wr_go = 1'b1;
          if (in_sof) begin
            // Restart the frame with this beat as (0,0).
            err_d = 1'b1;
            px_x  = '0;
            px_y  = '0;
            if (XLast == 7'd0) begin
              x_d = '0;
              y_d = 6'd1;
            end else begin
              x_d = 7'd1;
              y_d = '0;
            end
          end else if (x_q == XLast && y_q == YLast) begin
            x_d     = '0;
            y_d     = '0;
            state_d = StDrain;
          end else if (x_q == XLast) begin
            x_d = '0;
            y_d = y_q + 6'd1;
          end else begin
            x_d = x_q + 7'd1;
          end
        end
      end
      StDrain: begin
        if (!pipe_busy) begin
          bsel_d  = ~bsel_q;
          state_d = StSwap;
        end
      end
      StSwap: begin
        if (bc_sync == bsel_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StSync;
    endcase

    in_ready_d = (state_d == StIdle) || (state_d == StFill);
  end

  // Write pipeline; the back-buffer bit is captured at acceptance.
`ifdef FRAME_WRITER_GAMMA_EN
  always_comb begin
    s1_valid_d = wr_go;
    s1_addr_d  = s1_addr_q;
    s1_rgb_d   = s1_rgb_q;
    if (wr_go) begin
      s1_addr_d = {~bsel_q, px_y, px_x};
      s1_rgb_d  = in_data;
    end
    wr_d      = s1_valid_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (s1_valid_q) begin
      wr_addr_d = s1_addr_q;
      wr_data_d = {gamma_lut(s1_rgb_q[23:16]), gamma_lut(s1_rgb_q[15:8]),
                   gamma_lut(s1_rgb_q[7:0])};
    end
  end

  assign pipe_busy = s1_valid_q | wr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_rgb_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_rgb_q   <= s1_rgb_d;
    end
  end
`else
  always_comb begin
    wr_d      = wr_go;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_go) begin
      wr_addr_d = {~bsel_q, px_y, px_x};
      wr_data_d = {in_data[23:20], in_data[15:12], in_data[7:4]};
    end
  end

  assign pipe_busy = wr_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StSync;
      x_q        <= '0;
      y_q        <= '0;
      settle_q   <= '0;
      sync_q     <= '0;
      bsel_q     <= 1'b0;
      in_ready_q <= 1'b0;
      wr_q       <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      settle_q   <= settle_d;
      sync_q     <= sync_d;
      bsel_q     <= bsel_d;
      in_ready_q <= in_ready_d;
      wr_q       <= wr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign wr            = wr_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign buffer_select = bsel_q;
  assign frame_done    = done_q;
  assign frame_err     = err_q;

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer (default build: truncation, write latency N+1).
// A pixel-index model predicts every write address/data/cycle and every frame_err cycle.
`timescale 1ns/1ps
module tb_frame_writer;
  localparam int unsigned W     = 96;
  localparam int          FRAME = W * 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_sof = 1'b0;
  logic [23:0] in_data = '0;
  logic        buffer_current = 1'b0;
  logic        in_ready, wr, buffer_select, frame_done, frame_err;
  logic [13:0] wr_addr;
  logic [11:0] wr_data;

  frame_writer #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sof        (in_sof),
    .in_data       (in_data),
    .wr            (wr),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .buffer_select (buffer_select),
    .buffer_current(buffer_current),
    .frame_done    (frame_done),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] addr;
    logic [11:0] data;
    int          c;
  } wr_exp_t;

  wr_exp_t     exp_q[$];
  int          err_q[$];
  int          wr_total = 0;
  int          wcnt[16384];
  logic [11:0] shadow[16384];

  // Model state: back buffer selector, pixel index within the frame.
  logic m_bs = 1'b0;
  int   m_idx = 0;
  bit   m_in_frame = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (wr === 1'b1) begin
      wr_exp_t e;
      wr_total++;
      wcnt[wr_addr]++;
      shadow[wr_addr] = wr_data;
      if (exp_q.size() == 0) begin
        chk("unexpected_wr", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
        chk("wr_cycle", cyc, e.c);
      end
    end
    if (frame_err === 1'b1) begin
      if (err_q.size() == 0) chk("unexpected_err", 1, 0);
      else chk("err_cycle", cyc, err_q.pop_front());
    end
  end

  // Called in the cycle a beat is presented with in_ready high; it is accepted at the next edge.
  task automatic model_accept(input logic sof, input logic [23:0] d);
    wr_exp_t e;
    if (sof) begin
      if (m_in_frame) err_q.push_back(cyc + 1);
      m_in_frame = 1'b1;
      m_idx      = 0;
    end else if (!m_in_frame) begin
      err_q.push_back(cyc + 1);
      return;
    end
    e.addr = 14'((m_bs ? 0 : 8192) + (m_idx / W) * 128 + (m_idx % W));
    e.data = {d[23:20], d[15:12], d[7:4]};
    e.c    = cyc + 1;
    exp_q.push_back(e);
    m_idx++;
    if (m_idx == FRAME) begin
      m_in_frame = 1'b0;
      m_bs       = ~m_bs;
    end
  endtask

  task automatic send(input logic sof, input logic [23:0] d);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      chk("ready_timeout", 0, 1);
    end else begin
      model_accept(sof, d);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int npix, input int gap_pct, input int sof_at);
    logic [23:0] d;
    for (int i = 0; i < npix; i++) begin
      d = 24'($urandom);
      if (i == 40 * W + 5) d = 24'h80FF00;
      while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        in_data = 24'($urandom);
        in_sof  = 1'($urandom_range(1, 0));
        @(negedge clk);
      end
      send(i == 0 || i == sof_at, d);
    end
  endtask

  task automatic do_swap(input int delay);
    int n;
    int busy;
    n = 0;
    while (buffer_select !== m_bs && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bs_toggle", 32'(buffer_select), 32'(m_bs));
    chk("ready_low_swap", 32'(in_ready), 0);
    busy = 0;
    repeat (delay) begin
      @(negedge clk);
      if (in_ready !== 1'b0 || frame_done !== 1'b0) busy++;
    end
    chk("swap_hold", busy, 0);
    buffer_current = m_bs;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 50);
    chk("swap_latency", n, 3);
    @(negedge clk);
    chk("done_pulse_width", 32'(frame_done), 0);
    chk("ready_after_swap", 32'(in_ready), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_wr"}, 32'(wr), 0);
    chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_bsel"}, 32'(buffer_select), 0);
    chk({tag, "_done"}, 32'(frame_done), 0);
    chk({tag, "_err"}, 32'(frame_err), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w0;
    int nd;
    int dup;
    int busy;

    // Reset and SYNC exit
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (in_ready !== 1'b1 && n < 20);
    chk("sync_exit_2to3", 32'(n >= 2 && n <= 3), 1);

    // Frame 1: continuous, pixel (5,40) = 0x80FF00, long swap hold
    send_frame(FRAME, 0, -1);
    do_swap(1000);
    chk("px_5_40", 32'(shadow[14'h3405]), 32'h8F0);

    // IDLE beats without sof are discarded
    w0 = wr_total;
    repeat (3) send(1'b0, 24'($urandom));
    repeat (2) @(negedge clk);
    chk("idle_no_wr", wr_total - w0, 0);
    chk("idle_err_seen", err_q.size(), 0);

    // Frame 2: sof again at pixel 100 restarts the frame
    send_frame(FRAME + 100, 0, 100);
    do_swap(37);
    chk("restart_err_seen", err_q.size(), 0);

    // Frame 3: random valid gaps, every address written exactly once
    for (int a = 0; a < 16384; a++) wcnt[a] = 0;
    w0 = wr_total;
    send_frame(FRAME, 30, -1);
    do_swap(5);
    nd  = 0;
    dup = 0;
    for (int a = 0; a < 16384; a++) begin
      if (wcnt[a] != 0) nd++;
      if (wcnt[a] > 1) dup++;
    end
    chk("gap_writes", wr_total - w0, FRAME);
    chk("gap_distinct", nd, FRAME);
    chk("gap_dup", dup, 0);

    // Frame 4: reset mid-frame with buffer_select=1, buffer_current=1
    chk("pre_rst_bsel", 32'(buffer_select), 1);
    send_frame(3000, 10, -1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst        = 1'b0;
    m_bs       = 1'b0;
    m_in_frame = 1'b0;
    m_idx      = 0;
    busy = 0;
    repeat (50) begin
      @(negedge clk);
      if (in_ready !== 1'b0) busy++;
    end
    chk("sync_hold", busy, 0);
    buffer_current = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (in_ready !== 1'b1 && n < 10);
    chk("resync_ready", 32'(in_ready), 1);

    // Short partial frame after resync writes into buffer 1
    send_frame(200, 20, -1);
    repeat (4) @(negedge clk);
    chk("wr_queue_empty", exp_q.size(), 0);
    chk("err_queue_empty", err_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
